// File: rtl/intc_ext_pkg.sv
// Shared constants and types for the extended interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package intc_ext_pkg;

    // Per-channel trigger modes, 2 bits each in the MODE register
    localparam logic [1:0] MODE_RISE  = 2'b00;
    localparam logic [1:0] MODE_FALL  = 2'b01;
    localparam logic [1:0] MODE_BOTH  = 2'b10;
    localparam logic [1:0] MODE_LEVEL = 2'b11;

    // CSR offsets relative to BASE_ADDR
    localparam logic [4:0] OFS_ENABLE  = 5'd0;
    localparam logic [4:0] OFS_PENDING = 5'd1;
    localparam logic [4:0] OFS_MODE_LO = 5'd2;
    localparam logic [4:0] OFS_MODE_HI = 5'd3;
    localparam logic [4:0] OFS_RAW     = 5'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERTED = 2'd1,
        GAP      = 2'd2
    } irq_state_t;

endpackage

// File: rtl/intc_ext_channel.sv
// One interrupt channel: input synchroniser, edge/level decode, pending flop.
// Latency: input change before edge E sets pending at edge E+SYNC_STAGES.
// Backpressure: none; a same-cycle event beats a write-1-to-clear.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   in_i        raw interrupt source
//   primed_i    edge detection allowed (level mode ignores it)
//   mode_i      trigger mode (MODE_* from the package)
//   clr_i       write-1-to-clear strobe for this channel
//   s_o         synchronised input level
//   pending_o   latched pending flag
module intc_ext_channel
    import intc_ext_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_i,
    input  logic       primed_i,
    input  logic [1:0] mode_i,
    input  logic       clr_i,
    output logic       s_o,
    output logic       pending_o
);

    logic s;
    logic s_d_q;
    logic evt;
    logic pending_q;
    logic pending_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            // Source is already in the clk domain
            assign s = in_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= in_i;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // s_d_q follows s regardless of mode, so a MODE change never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            s_d_q <= 1'b0;
        end else begin
            s_d_q <= s;
        end
    end

    always_comb begin
        evt = 1'b0;
        case (mode_i)
            MODE_RISE: evt = primed_i & s & ~s_d_q;
            MODE_FALL: evt = primed_i & ~s & s_d_q;
            MODE_BOTH: evt = primed_i & (s ^ s_d_q);
            default:   evt = s;  // level-high, never suppressed
        endcase
    end

    // Event is ORed after the clear so it wins in the same cycle
    assign pending_d = (pending_q & ~clr_i) | evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign s_o       = s;
    assign pending_o = pending_q;

endmodule

// File: rtl/intc_ext.sv
// Interrupt controller: per-channel triggers, enable mask, W1C pending, re-armed irq.
// Latency: pending at E+SYNC_STAGES after an input change, irq one edge later; csr_do combinational.
// Backpressure: none; single-cycle CSR writes always accepted.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   csr_a       CSR address (5 consecutive addresses from BASE_ADDR)
//   csr_di      CSR write data, csr_we one-cycle write strobe
//   csr_do      CSR read data, 0 outside this block's window
//   int_in      raw interrupt sources, active-high
//   irq         registered interrupt request, active-high
module intc_ext
    import intc_ext_pkg::*;
#(
    parameter logic [4:0]  BASE_ADDR    = 5'h1c,
    parameter int          NUM_INTS     = 8,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [7:0]  DFL_ENABLE   = 8'h00,
    parameter logic [15:0] DFL_MODE     = 16'h0000,
    parameter int          REARM_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic [NUM_INTS-1:0] int_in,
    output logic                irq
);

    localparam logic [7:0]  CH_MASK    = 8'((9'd1 << NUM_INTS) - 9'd1);
    localparam logic [15:0] MODE_MASK  = 16'((17'd1 << (2 * NUM_INTS)) - 17'd1);
    localparam bit          REARM_EN   = (REARM_CYCLES > 0);
    localparam logic [7:0]  GAP_LOAD   = REARM_EN ? 8'(REARM_CYCLES - 1) : 8'd0;
    // Edge detection waits until the synchroniser holds only post-reset
    // samples and s_d has caught up, so a source already high at reset
    // is not mistaken for a rising edge.
    localparam logic [2:0]  PRIME_CLKS = 3'(SYNC_STAGES + 1);

    logic [4:0]  ofs;
    logic [7:0]  enable_q, enable_d;
    logic [15:0] mode_q, mode_d;
    logic [2:0]  prime_cnt_q;
    logic        primed;
    logic [7:0]  pending;
    logic [7:0]  raw;
    logic [7:0]  clr;
    logic        clr_any;
    logic        active;

    irq_state_t  state_q;
    logic [7:0]  gap_cnt_q;
    logic        irq_q;

    // Window offset; wraps modulo 32 like the bus itself
    assign ofs = csr_a - BASE_ADDR;

    assign clr     = (csr_we && (ofs == OFS_PENDING)) ? (csr_di & CH_MASK) : 8'h00;
    assign clr_any = |clr;
    assign active  = |(pending & enable_q);
    assign primed  = (prime_cnt_q == PRIME_CLKS);

    generate
        for (genvar i = 0; i < 8; i++) begin : g_ch
            if (i < NUM_INTS) begin : g_on
                intc_ext_channel #(
                    .SYNC_STAGES(SYNC_STAGES)
                ) u_channel (
                    .clk      (clk),
                    .rst      (rst),
                    .in_i     (int_in[i]),
                    .primed_i (primed),
                    .mode_i   (mode_q[2*i +: 2]),
                    .clr_i    (clr[i]),
                    .s_o      (raw[i]),
                    .pending_o(pending[i])
                );
            end else begin : g_off
                assign raw[i]     = 1'b0;
                assign pending[i] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        if (csr_we) begin
            case (ofs)
                OFS_ENABLE:  enable_d     = csr_di & CH_MASK;
                OFS_MODE_LO: mode_d[7:0]  = csr_di & MODE_MASK[7:0];
                OFS_MODE_HI: mode_d[15:8] = csr_di & MODE_MASK[15:8];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q    <= DFL_ENABLE & CH_MASK;
            mode_q      <= DFL_MODE & MODE_MASK;
            prime_cnt_q <= 3'd0;
        end else begin
            enable_q <= enable_d;
            mode_q   <= mode_d;
            if (!primed) begin
                prime_cnt_q <= prime_cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        csr_do = 8'h00;
        case (ofs)
            OFS_ENABLE:  csr_do = enable_q;
            OFS_PENDING: csr_do = pending;
            OFS_MODE_LO: csr_do = mode_q[7:0];
            OFS_MODE_HI: csr_do = mode_q[15:8];
            OFS_RAW:     csr_do = raw;
            default:     csr_do = 8'h00;
        endcase
    end

    // IRQ sequencer. Clearing any cause while asserted forces a low gap so an
    // edge-sensitive consumer sees a fresh edge if other causes remain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gap_cnt_q <= 8'd0;
            irq_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (active) begin
                        state_q <= ASSERTED;
                        irq_q   <= 1'b1;
                    end
                end
                ASSERTED: begin
                    if (clr_any && REARM_EN) begin
                        state_q   <= GAP;
                        gap_cnt_q <= GAP_LOAD;
                        irq_q     <= 1'b0;
                    end else if (!active) begin
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                GAP: begin
                    // IDLE re-evaluates active on the following edge
                    if (gap_cnt_q == 8'd0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq = irq_q;

endmodule
